// File: rtl/shift_and_subtract_binary_divider.sv
// ---------------------------------------------------------------------------
// shift_and_subtract_binary_divider
//
// Multi-cycle restoring unsigned divider. Produces Q = A / B and R = A % B,
// retiring one quotient bit per clock. Companion to the shift-and-add
// multiplier in the arithmetic datapath.
//
// Ports:
//   clk          in   1   clock, all state updates on posedge
//   rst          in   1   asynchronous, active-low reset
//   start        in   1   request; accepted only while busy==0
//   A            in   m   dividend, sampled on the accepting edge
//   B            in   n   divisor, sampled on the accepting edge
//   busy         out  1   high while a division is in progress
//   done         out  1   one-cycle pulse; Q/R/div_by_zero valid
//   Q            out  m   quotient, held until the next completion
//   R            out  n   remainder, held until the next completion
//   div_by_zero  out  1   last completed op had B==0; held with Q/R
//
// Latency from accepting edge to done: m clocks, or 1 clock when B==0.
// ---------------------------------------------------------------------------
module shift_and_subtract_binary_divider #(
    parameter int m = 8,
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [m-1:0] A,
    input  logic [n-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [m-1:0] Q,
    output logic [n-1:0] R,
    output logic         div_by_zero
);

    localparam int CW = $clog2(m + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Working registers. aq shifts the dividend out of its MSB while the
    // quotient bits enter at its LSB. The partial remainder is kept in n bits:
    // after each restoring step it is strictly below the divisor, so the extra
    // bit only exists transiently in the shifted value below.
    logic [m-1:0]  aq;
    logic [n-1:0]  bd;
    logic [n-1:0]  p;
    logic [CW-1:0] cnt;

    logic [n:0]    p_shift;
    logic [n-1:0]  p_nxt;
    logic [m-1:0]  aq_nxt;
    logic          accept;
    logic          last_iter;
    logic          bd_zero;

    assign accept    = start && (state != CALC);
    assign last_iter = (cnt == CW'(m - 1));
    assign bd_zero   = (bd == '0);

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // One restoring iteration: shift in the next dividend bit, subtract the
    // divisor if it fits and record the outcome as the new quotient bit.
    always_comb begin
        p_shift = {p, aq[m-1]};
        aq_nxt  = {aq[m-2:0], 1'b0};
        p_nxt   = p_shift[n-1:0];
        if (p_shift >= {1'b0, bd}) begin
            p_nxt     = n'(p_shift - {1'b0, bd});
            aq_nxt[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (bd_zero || last_iter) state_nxt = DONE;
            DONE: state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath working set carries no reset: it is always reloaded on the
    // accepting edge before it is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            aq  <= A;
            bd  <= B;
            p   <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            aq  <= aq_nxt;
            p   <= p_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers update only on completion edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (state == CALC) begin
            if (bd_zero) begin
                // aq has not shifted yet on the first CALC edge, so it still
                // holds the original dividend.
                Q           <= '1;
                R           <= aq[n-1:0];
                div_by_zero <= 1'b1;
            end else if (last_iter) begin
                Q           <= aq_nxt;
                R           <= p_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
module tb_shift_and_subtract_binary_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Q;
    logic [7:0] R;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    shift_and_subtract_binary_divider #(.m(8), .n(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Present a request at the falling edge; returns 1 ns after the accepting edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done (bounded), then check latency and results.
    task automatic finish_op(input string name, input int cyc0, input int exp_lat,
                             input logic [7:0] eq, input logic [7:0] er, input logic edz);
        int cyc;
        cyc = cyc0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, exp_lat);
        chk({name, "_Q"}, Q, eq);
        chk({name, "_R"}, R, er);
        chk({name, "_dz"}, div_by_zero, edz);
        chk({name, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        logic [7:0] ra, rb, eq, er;
        logic       edz;
        int         elat;
        int         bad;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 8};
        vecs[1] = '{8'd5,   8'd10,  8'd0,   8'd5,  1'b0, 8};
        vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8};
        vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8};
        vecs[4] = '{8'd37,  8'd0,   8'd255, 8'd37, 1'b1, 1};
        vecs[5] = '{8'd200, 8'd3,   8'd66,  8'd2,  1'b0, 8};
        vecs[6] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 8};
        vecs[7] = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0, 8};

        start = 1'b0;
        A     = '0;
        B     = '0;
        rst   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_Q", Q, 0);
        chk("reset_R", R, 0);
        chk("reset_dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table: each op followed by an idle cycle to see done drop and results hold.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_busy_after_accept", i), busy, 1);
            finish_op($sformatf("vec%0d", i), 0, vecs[i].lat, vecs[i].q, vecs[i].r, vecs[i].dz);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse_width", i), done, 0);
            chk($sformatf("vec%0d_Q_held", i), Q, vecs[i].q);
            chk($sformatf("vec%0d_R_held", i), R, vecs[i].r);
        end

        // start pulsed during an op with different operands must be ignored.
        start_op(8'd100, 8'd7);
        @(posedge clk);
        @(posedge clk);
        #1;
        A     = 8'd9;
        B     = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = 8'd0;
        B     = 8'd0;
        chk("ignored_start_busy", busy, 1);
        finish_op("ignored_start", 3, 8, 8'd14, 8'd2, 1'b0);

        // Back-to-back: request presented in the DONE cycle.
        start_op(8'd81, 8'd9);
        chk("b2b_done_dropped", done, 0);
        chk("b2b_busy_rose", busy, 1);
        chk("b2b_prev_Q_held", Q, 14);
        finish_op("b2b", 0, 8, 8'd9, 8'd0, 1'b0);

        // Asynchronous reset in the middle of an op.
        start_op(8'd100, 8'd7);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_Q", Q, 0);
        chk("midreset_R", R, 0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) bad++;
        end
        chk("midreset_no_done_after", bad, 0);
        start_op(8'd200, 8'd3);
        finish_op("after_reset", 0, 8, 8'd66, 8'd2, 1'b0);

        // Random ops against a behavioural reference, random back-to-back spacing.
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (rb == 0) begin
                eq = 8'hFF; er = ra; edz = 1'b1; elat = 1;
            end else begin
                eq = ra / rb; er = ra % rb; edz = 1'b0; elat = 8;
            end
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
            start_op(ra, rb);
            finish_op($sformatf("rand%0d_%0d_%0d", k, ra, rb), 0, elat, eq, er, edz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
